// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cacheline port to a 64-bit burst memory bus (4 beats per line).
// Define CACHELINE_ADAPTOR_EARLY_RESP_EN to drop the DONE state and respond on the final beat.
module cacheline_adaptor #(
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned BURST_LEN   = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [BURST_WIDTH*BURST_LEN-1:0] line_i,
    output logic [BURST_WIDTH*BURST_LEN-1:0] line_o,
    input  logic [31:0]                      address_i,
    input  logic                             read_i,
    input  logic                             write_i,
    output logic                             resp_o,

    input  logic [BURST_WIDTH-1:0]           burst_i,
    output logic [BURST_WIDTH-1:0]           burst_o,
    output logic [31:0]                      address_o,
    output logic                             read_o,
    output logic                             write_o,
    input  logic                             resp_i
);

    localparam int unsigned LineWidth  = BURST_WIDTH * BURST_LEN;
    localparam int unsigned CntWidth   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [31:0] AlignMask  = ~(32'(LineWidth / 8) - 32'd1);
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BURST_LEN - 1);

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
    localparam bit EarlyResp = 1'b1;
`else
    localparam bit EarlyResp = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_e;

    state_e                                  state_q, state_d;
    logic [CntWidth-1:0]                     cnt_q, cnt_d;
    logic [BURST_LEN-1:0][BURST_WIDTH-1:0]   buf_q, buf_d;
    logic [LineWidth-1:0]                    line_q, line_d;
    logic [31:0]                             addr_q, addr_d;
    state_e                                  end_state;

    // Early-response builds skip DONE and return straight to IDLE after the last beat.
    assign end_state = EarlyResp ? StIdle : StDone;
    assign address_o = addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        line_d  = line_q;
        addr_d  = addr_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        line_o  = line_q;

        unique case (state_q)
            StIdle: begin
                if (write_i) begin
                    buf_d   = line_i;
                    addr_d  = address_i & AlignMask;
                    cnt_d   = '0;
                    state_d = StWr;
                end else if (read_i) begin
                    addr_d  = address_i & AlignMask;
                    cnt_d   = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                read_o = 1'b1;
                if (resp_i) begin
                    buf_d[cnt_q] = burst_i;
                    cnt_d        = cnt_q + CntWidth'(1);
                    if (cnt_q == LastBeat) begin
                        // Whole line is committed at once so line_o never shows a partial fill.
                        line_d  = buf_d;
                        cnt_d   = '0;
                        state_d = end_state;
                        if (EarlyResp) begin
                            resp_o = 1'b1;
                            line_o = buf_d;
                        end
                    end
                end
            end
            StWr: begin
                write_o = 1'b1;
                burst_o = buf_q[cnt_q];
                if (resp_i) begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        state_d = end_state;
                        if (EarlyResp) begin
                            resp_o = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                resp_o  = 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a transaction-level reference model.
// Honours CACHELINE_ADAPTOR_EARLY_RESP_EN to match the DUT build.
module tb_cacheline_adaptor;

    localparam int BW = 64;
    localparam int BL = 4;
    localparam int LW = BW * BL;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_i, line_o;
    logic [31:0]   address_i, address_o;
    logic          read_i, write_i, resp_o;
    logic [BW-1:0] burst_i, burst_o;
    logic          read_o, write_o, resp_i;

    cacheline_adaptor #(
        .BURST_WIDTH (BW),
        .BURST_LEN   (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [LW-1:0] act,
                                  input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    // Reference model state: 0 idle, 1 filling, 2 writing back, 3 response pending.
    int            m_mode  = 0;
    int            m_beats = 0;
    logic [31:0]   m_addr  = '0;
    logic [LW-1:0] m_wline = '0;
    logic [LW-1:0] m_fill  = '0;
    logic [LW-1:0] m_line  = '0;

    int          cyc = 0;
    int          resp_cnt, rd_hi, wr_hi, resp_cyc, start_cyc;
    logic [63:0] wbeats[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are sampled 2 time units after the negedge where inputs change.
    always @(negedge clk) begin
        logic          e_rd, e_wr, e_resp, fin;
        logic [LW-1:0] e_line;
        logic [BW-1:0] e_burst;
        #2;
        if (rst) begin
            m_mode = 0; m_beats = 0; m_addr = '0; m_line = '0; m_fill = '0;
        end
        e_rd    = (m_mode == 1);
        e_wr    = (m_mode == 2);
        e_resp  = (m_mode == 3);
        e_line  = m_line;
        e_burst = m_wline[m_beats*BW +: BW];
        fin     = (e_rd || e_wr) && resp_i && (m_beats == BL - 1);
        if (Early && fin) begin
            e_resp = 1'b1;
            if (e_rd) begin
                e_line = m_fill;
                e_line[LW-1 -: BW] = burst_i;
            end
        end
        check("read_o", LW'(read_o), LW'(e_rd));
        check("write_o", LW'(write_o), LW'(e_wr));
        check("resp_o", LW'(resp_o), LW'(e_resp));
        check("address_o", LW'(address_o), LW'(m_addr));
        check("line_o", line_o, e_line);
        if (e_wr) check("burst_o", LW'(burst_o), LW'(e_burst));

        if (resp_o) begin resp_cnt++; resp_cyc = cyc; end
        if (read_o) rd_hi++;
        if (write_o) wr_hi++;
        if (write_o && resp_i) wbeats.push_back(burst_o);

        if (!rst) begin
            case (m_mode)
                0: begin
                    if (write_i) begin
                        m_mode = 2; m_wline = line_i; m_beats = 0;
                        m_addr = {address_i[31:5], 5'b0};
                    end else if (read_i) begin
                        m_mode = 1; m_beats = 0;
                        m_addr = {address_i[31:5], 5'b0};
                    end
                end
                1, 2: begin
                    if (resp_i) begin
                        if (m_mode == 1) m_fill[m_beats*BW +: BW] = burst_i;
                        m_beats++;
                        if (m_beats == BL) begin
                            if (m_mode == 1) m_line = m_fill;
                            m_beats = 0;
                            m_mode  = Early ? 0 : 3;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic clear_stats();
        resp_cnt = 0; rd_hi = 0; wr_hi = 0; resp_cyc = -1; start_cyc = -1;
        wbeats.delete();
    endtask

    // Reactive memory: waits for a burst, optionally stalls before one beat or aborts with reset.
    task automatic serve(input logic [LW-1:0] rd, input int stall_beat, input int stall_n,
                         input int abort_after, input bit hold_req);
        int n = 0;
        while (!(read_o || write_o) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("burst_start", LW'(n < 10), LW'(1));
        start_cyc = cyc;
        if (!hold_req) begin read_i = 1'b0; write_i = 1'b0; end
        for (int j = 0; j < BL; j++) begin
            if (j == abort_after) begin
                resp_i = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; read_i = 1'b0; write_i = 1'b0;
                return;
            end
            if (j == stall_beat) begin
                repeat (stall_n) begin resp_i = 1'b0; @(negedge clk); end
            end
            resp_i = 1'b1; burst_i = rd[j*BW +: BW];
            @(negedge clk);
        end
        resp_i = 1'b0; burst_i = '0;
    endtask

    logic [LW-1:0] fill1, fill2, wb1, wb2, wb3;
    logic [63:0]   d[4];
    int            req_cyc;

    initial begin
        fill1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        fill2 = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        d[0] = 64'hD000_0000_0000_00D0; d[1] = 64'hD111_1111_1111_11D1;
        d[2] = 64'hD222_2222_2222_22D2; d[3] = 64'hD333_3333_3333_33D3;
        wb1 = {d[3], d[2], d[1], d[0]};
        wb2 = {64'hBEEF_0003, 64'hBEEF_0002, 64'hBEEF_0001, 64'hBEEF_0000};
        wb3 = {64'h5A5A_0003, 64'h5A5A_0002, 64'h5A5A_0001, 64'h5A5A_0000};

        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_line_o", line_o, '0);
        check("rst_address_o", LW'(address_o), '0);
        check("rst_resp_o", LW'(resp_o), '0);

        // Fill
        @(negedge clk);
        clear_stats();
        read_i = 1'b1; address_i = 32'h1234_5678; req_cyc = cyc;
        serve(fill1, 99, 0, 99, 1'b0);
        repeat (3) @(negedge clk);
        check("fill_line", line_o, fill1);
        check("fill_addr", LW'(address_o), LW'(32'h1234_5660));
        check("fill_resp_cnt", LW'(resp_cnt), LW'(1));
        check("fill_resp_cycle", LW'(resp_cyc - req_cyc), LW'(Early ? 4 : 5));
        check("fill_read_cycles", LW'(rd_hi), LW'(4));

        // Writeback with two stalls between beats 1 and 2
        clear_stats();
        write_i = 1'b1; line_i = wb1; address_i = 32'h0000_1F3F;
        serve('0, 2, 2, 99, 1'b0);
        repeat (3) @(negedge clk);
        check("wb_beat_count", LW'(wbeats.size()), LW'(4));
        for (int i = 0; i < 4; i++)
            if (i < wbeats.size()) check("wb_beat", LW'(wbeats[i]), LW'(d[i]));
        check("wb_write_cycles", LW'(wr_hi), LW'(6));
        check("wb_resp_cnt", LW'(resp_cnt), LW'(1));
        check("wb_keeps_line", line_o, fill1);

        // Read/write collision: write wins
        clear_stats();
        read_i = 1'b1; write_i = 1'b1; line_i = wb3; address_i = 32'h8000_0044;
        serve('0, 99, 0, 99, 1'b0);
        repeat (3) @(negedge clk);
        check("col_read_cycles", LW'(rd_hi), LW'(0));
        check("col_write_cycles", LW'(wr_hi), LW'(4));
        check("col_resp_cnt", LW'(resp_cnt), LW'(1));
        check("col_addr", LW'(address_o), LW'(32'h8000_0040));

        // Reset after two beats of a fill, then a clean fill
        clear_stats();
        read_i = 1'b1; address_i = 32'h0000_0100;
        serve(fill2, 99, 0, 2, 1'b0);
        check("abort_line", line_o, '0);
        check("abort_addr", LW'(address_o), '0);
        repeat (2) @(negedge clk);
        check("abort_resp_cnt", LW'(resp_cnt), LW'(0));
        clear_stats();
        read_i = 1'b1; address_i = 32'hABCD_EF9F;
        serve(fill2, 1, 1, 99, 1'b0);
        repeat (3) @(negedge clk);
        check("refill_line", line_o, fill2);
        check("refill_resp_cnt", LW'(resp_cnt), LW'(1));

        // Back-to-back: fill with read_i held, then writeback requested after the last beat
        clear_stats();
        read_i = 1'b1; address_i = 32'h0040_0020;
        serve(fill1, 99, 0, 99, 1'b1);
        read_i = 1'b0; write_i = 1'b1; line_i = wb2; address_i = 32'h0040_0080;
        serve('0, 99, 0, 99, 1'b0);
        check("b2b_accept_gap", LW'(start_cyc - resp_cyc), LW'(2));
        repeat (3) @(negedge clk);
        check("b2b_resp_cnt", LW'(resp_cnt), LW'(2));
        check("b2b_read_cycles", LW'(rd_hi), LW'(4));
        check("b2b_line_kept", line_o, fill1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 cache, between its 256-bit line port and the 64-bit burst physical-memory bus.
- Serialises one cacheline writeback into 4 beats and assembles 4 read beats into one cacheline.
- Presents a single-request, single-response handshake to the cache.
- Owns all burst sequencing, so the cache control FSM sees a whole line per transaction.

Parameters:
- BURST_WIDTH, 64, bits per memory beat.
- BURST_LEN, 4, beats per line; line width = BURST_WIDTH*BURST_LEN = 256.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_i  input  256  writeback line from the cache (pmem_wdata side).
- line_o  output  256  assembled fill line to the cache (pmem_rdata side).
- address_i  input  32  line address from the cache.
- read_i  input  1  cache requests a line fill.
- write_i  input  1  cache requests a line writeback.
- resp_o  output  1  one-cycle completion pulse to the cache.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  line-aligned burst address to memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat strobe; high for each consecutive beat.

Behaviour:
- Reset (async, rst=1): state IDLE, beat counter 0. line_o, burst_o, address_o = 0. read_o, write_o, resp_o = 0. Takes effect immediately, including mid-burst; the aborted transaction is dropped with no resp_o.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Write accept: write_i=1 latches line_i into shift buffer and {address_i[31:5],5'b0} into address_o; next state WR.
  - Read accept: else read_i=1 latches the same aligned address; next state RD.
  - Simultaneous read_i and write_i: write wins. Read is not serviced until the cache re-requests after resp_o.
  - Requests are sampled only in IDLE.
- RD:
  - read_o=1 throughout.
  - On each cycle with resp_i=1, burst_i is stored into beat slot k (k=0 is line bits 63:0), then k increments.
  - After beat BURST_LEN-1 is stored: read_o drops and state goes to DONE.
  - resp_i=0 cycles (stalls) are allowed before or between beats; the counter holds.
- WR:
  - write_o=1 throughout; burst_o = buffer beat k.
  - On each resp_i=1, k increments.
  - After beat BURST_LEN-1: write_o drops and state goes to DONE.
- DONE: resp_o=1 for exactly one cycle; next state IDLE; k cleared.
- line_o holds the last completed fill until the next fill completes. It is never partially visible; slots are staged and copied to line_o on entry to DONE.
- Latency: request accepted at cycle 0; read_o/write_o high from cycle 1; with back-to-back beats on cycles 1..4, resp_o is high on cycle 5.
- Counter width is clog2(BURST_LEN) bits and wraps to 0 on completion.
- resp_i while IDLE or DONE is ignored.
- address_o stays stable for the whole burst, even if address_i changes.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_EARLY_RESP_EN.
- Defined: the DONE state is removed. resp_o is asserted combinationally in the cycle the final beat has resp_i=1.
  - For reads, line_o in that cycle = staged slots 0..BURST_LEN-2 concatenated with burst_i in the top slot.
  - The next request may be accepted the following cycle. Latency is one cycle shorter (resp_o on cycle 4 in the example above).
- Undefined: registered DONE behaviour as described above.

Test Plan:
- Fill: read_i=1, address_i=0x1234_5678; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back. Required: address_o=0x1234_5660, read_o high cycles 1-4, resp_o high cycle 5 only, line_o={0x44..,0x33..,0x22..,0x11..}.
- Writeback: write_i=1, line_i={D3,D2,D1,D0}, with 2 stall cycles (resp_i=0) between beats 1 and 2. Required: burst_o shows D0,D1,D2,D3 in order, each held across its stalls; write_o high until the 4th beat; resp_o is one pulse.
- Collision: read_i=write_i=1 in IDLE. Required: write burst only, read_o stays 0, single resp_o.
- Reset mid-burst: assert rst after beat 2 of a fill. Required: all outputs 0 immediately, no resp_o, line_o=0. A following fill completes correctly.
- Back-to-back: fill then writeback with request lines held high. Required: the second request is accepted only in IDLE after resp_o; line_o is unchanged by the writeback.
- With CACHELINE_ADAPTOR_EARLY_RESP_EN defined, rerun the fill test. Required: resp_o on cycle 4, coincident with the final resp_i, and the correct line_o in that cycle.
